// File: rtl/attack_tx.sv
// Attacker-side shot launcher: validates a switch-selected target and sends it to the opponent board over a req/ack handshake.
// Optional multi-cell salvo shots are compiled in with the ATTACK_TX_SALVO_EN macro.
//
// state    | meaning
// IDLE     | waiting for a fire rising edge
// CHECK    | validating the latched shot
// SEND     | attack word presented, waiting for opp_ready_i
// WAIT_REL | shot taken, waiting for opp_ready_i to drop
// ERR      | shot rejected, waiting for fire release
// WON      | opponent eliminated, only clr leaves
module attack_tx #(
    parameter int N         = 16,
    parameter int MAX_SALVO = 3,
    localparam int CW       = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [N-1:0]  sel_i,
    input  logic          fire_i,
    input  logic          opp_ready_i,
    input  logic          opp_alive_i,
    output logic [N-1:0]  attack_pos_o,
    output logic          attack_valid_o,
    output logic [N-1:0]  fired_mask_o,
    output logic [CW-1:0] shot_count_o,
    output logic          err_o,
    output logic          won_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        SEND     = 3'd2,
        WAIT_REL = 3'd3,
        ERR      = 3'd4,
        WON      = 3'd5
    } state_t;

`ifdef ATTACK_TX_SALVO_EN
    localparam int SHOT_MAX = MAX_SALVO;
`else
    // Single-cell shots only; a zero salvo limit would still forbid every shot.
    localparam int SHOT_MAX = (MAX_SALVO < 1) ? MAX_SALVO : 1;
`endif

    state_t        state_q;
    logic [N-1:0]  pos_q;
    logic [N-1:0]  attack_pos_q;
    logic          attack_valid_q;
    logic [N-1:0]  mask_q;
    logic [CW-1:0] count_q;
    logic          err_q;
    logic          won_q;
    logic          armed_q;
    logic          fire_q;

    logic [CW-1:0] pop_d;
    logic [CW-1:0] incr_d;
    logic [CW-1:0] count_d;
    logic [N-1:0]  mask_d;
    logic          shot_ok_d;

    function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        pop_d     = popcnt(pos_q);
`ifdef ATTACK_TX_SALVO_EN
        incr_d    = pop_d;
`else
        incr_d    = CW'(1);
`endif
        count_d   = count_q + incr_d;
        mask_d    = mask_q | pos_q;
        shot_ok_d = (pos_q != '0) && ((pos_q & mask_q) == '0) &&
                    (pop_d != '0) && (pop_d <= CW'(SHOT_MAX));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q        <= IDLE;
            pos_q          <= '0;
            attack_pos_q   <= '0;
            attack_valid_q <= 1'b0;
            mask_q         <= '0;
            count_q        <= '0;
            err_q          <= 1'b0;
            won_q          <= 1'b0;
            armed_q        <= 1'b0;
            fire_q         <= 1'b1;
        end else begin
            fire_q <= fire_i;
            if (opp_alive_i) begin
                armed_q <= 1'b1;
            end
            // An in-flight shot is dropped without touching the mask.
            if (armed_q && !opp_alive_i) begin
                state_q        <= WON;
                won_q          <= 1'b1;
                attack_valid_q <= 1'b0;
                attack_pos_q   <= '0;
                err_q          <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fire_i && !fire_q) begin
                            pos_q   <= sel_i;
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (shot_ok_d) begin
                            attack_pos_q   <= pos_q;
                            attack_valid_q <= 1'b1;
                            state_q        <= SEND;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                    SEND: begin
                        if (opp_ready_i) begin
                            mask_q         <= mask_d;
                            count_q        <= count_d;
                            attack_pos_q   <= '0;
                            attack_valid_q <= 1'b0;
                            state_q        <= WAIT_REL;
                        end
                    end
                    WAIT_REL: begin
                        if (!opp_ready_i) begin
                            state_q <= IDLE;
                        end
                    end
                    ERR: begin
                        if (!fire_i) begin
                            err_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    WON: begin
                        state_q <= WON;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign attack_pos_o   = attack_pos_q;
    assign attack_valid_o = attack_valid_q;
    assign fired_mask_o   = mask_q;
    assign shot_count_o   = count_q;
    assign err_o          = err_q;
    assign won_o          = won_q;

endmodule

// File: tb/tb_attack_tx.sv
// Scoreboard bench for attack_tx: stimulus pushes expected events, a negedge monitor pops and checks them.
module tb_attack_tx;

    localparam int K_SEND = 0;
    localparam int K_ERR  = 1;
    localparam int K_WON  = 2;

    logic        clk;
    logic        clr;
    logic [15:0] sel;
    logic        fire;
    logic        opp_ready;
    logic        opp_alive;
    logic [15:0] attack_pos;
    logic        attack_valid;
    logic [15:0] fired_mask;
    logic [4:0]  shot_count;
    logic        err;
    logic        won;

    attack_tx #(.N(16), .MAX_SALVO(3)) dut (
        .clk            (clk),
        .clr            (clr),
        .sel_i          (sel),
        .fire_i         (fire),
        .opp_ready_i    (opp_ready),
        .opp_alive_i    (opp_alive),
        .attack_pos_o   (attack_pos),
        .attack_valid_o (attack_valid),
        .fired_mask_o   (fired_mask),
        .shot_count_o   (shot_count),
        .err_o          (err),
        .won_o          (won)
    );

    typedef struct {
        int          kind;
        logic [15:0] pos;
        logic [15:0] mask;
        logic [4:0]  cnt;
        int          hold;
        bit          abandon;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_mask = '0;
    logic [4:0]  exp_cnt  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [4:0] incr(input logic [15:0] p);
`ifdef ATTACK_TX_SALVO_EN
        return 5'($countones(p));
`else
        return (p != 16'h0) ? 5'd1 : 5'd0;
`endif
    endfunction

    task automatic push(input int kind, input logic [15:0] pos, input int hold, input bit abandon);
        exp_t e;
        if (kind == K_SEND && !abandon) begin
            exp_mask = exp_mask | pos;
            exp_cnt  = exp_cnt + incr(pos);
        end
        e.kind    = kind;
        e.pos     = pos;
        e.mask    = exp_mask;
        e.cnt     = exp_cnt;
        e.hold    = hold;
        e.abandon = abandon;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the CHECK cycle that follows the sampled edge.
    task automatic pulse_fire(input logic [15:0] s);
        tick();
        sel  = s;
        fire = 1'b1;
        tick();
        fire = 1'b0;
    endtask

    bit   pv = 1'b0;
    bit   pe = 1'b0;
    bit   pw = 1'b0;
    int   hold_cnt = 0;
    exp_t cur;
    exp_t ev;

    initial begin
        cur.abandon = 1'b1;
        forever begin
            @(negedge clk);
            if (attack_valid && !pv) begin
                hold_cnt = 1;
                if (q.size() == 0) begin
                    chk("unexpected_send", {31'b0, attack_valid}, 32'd0);
                    cur.abandon = 1'b1;
                end else begin
                    cur = q.pop_front();
                    chk("send_kind", cur.kind, K_SEND);
                    chk("send_pos", {16'b0, attack_pos}, {16'b0, cur.pos});
                end
            end else if (attack_valid) begin
                hold_cnt++;
            end
            if (!attack_valid && pv && !cur.abandon) begin
                if (cur.hold != 0) chk("send_hold", hold_cnt, cur.hold);
                chk("mask_after_send", {16'b0, fired_mask}, {16'b0, cur.mask});
                chk("count_after_send", {27'b0, shot_count}, {27'b0, cur.cnt});
            end
            if (err && !pe) begin
                if (q.size() == 0) chk("unexpected_err", {31'b0, err}, 32'd0);
                else begin
                    ev = q.pop_front();
                    chk("err_kind", K_ERR, ev.kind);
                end
            end
            if (won && !pw) begin
                if (q.size() == 0) chk("unexpected_won", {31'b0, won}, 32'd0);
                else begin
                    ev = q.pop_front();
                    chk("won_kind", K_WON, ev.kind);
                end
            end
            pv = attack_valid;
            pe = err;
            pw = won;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; fire = 1'b1; sel = 16'h0001; opp_ready = 1'b0; opp_alive = 1'b0;
        repeat (3) tick();
        clr = 1'b0;
        @(negedge clk);
        chk("rst_attack_pos", {16'b0, attack_pos}, 32'h0);
        chk("rst_valid", {31'b0, attack_valid}, 32'd0);
        chk("rst_mask", {16'b0, fired_mask}, 32'h0);
        chk("rst_count", {27'b0, shot_count}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_won", {31'b0, won}, 32'd0);

        // fire held through reset must not shoot; dead-from-reset opponent is not a win
        repeat (5) tick();
        @(negedge clk);
        chk("held_fire_valid", {31'b0, attack_valid}, 32'd0);
        chk("held_fire_err", {31'b0, err}, 32'd0);
        chk("unarmed_won", {31'b0, won}, 32'd0);
        tick(); fire = 1'b0;
        tick(); opp_alive = 1'b1;
        tick();

        // single shot, ready raised on the third valid cycle
        push(K_SEND, 16'h0010, 3, 1'b0);
        pulse_fire(16'h0010);
        @(negedge clk);
        chk("check_cycle_valid", {31'b0, attack_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("send_latency", {31'b0, attack_valid}, 32'd1);
        tick();
        tick(); opp_ready = 1'b1;
        tick(); opp_ready = 1'b0;
        @(negedge clk);
        chk("single_mask", {16'b0, fired_mask}, 32'h0010);
        chk("single_count", {27'b0, shot_count}, 32'd1);
        tick(); tick();

        // repeat cell
        push(K_ERR, 16'h0010, 0, 1'b0);
        tick(); sel = 16'h0010; fire = 1'b1;
        tick();
        @(negedge clk);
        chk("repeat_err_check_cycle", {31'b0, err}, 32'd0);
        tick();
        @(negedge clk);
        chk("repeat_err", {31'b0, err}, 32'd1);
        chk("repeat_no_valid", {31'b0, attack_valid}, 32'd0);
        tick(); tick();
        @(negedge clk);
        chk("err_held", {31'b0, err}, 32'd1);
        tick(); fire = 1'b0;
        tick();
        @(negedge clk);
        chk("err_cleared", {31'b0, err}, 32'd0);
        tick();

        // two-cell shot, opponent already ready
        opp_ready = 1'b1;
`ifdef ATTACK_TX_SALVO_EN
        push(K_SEND, 16'h0003, 1, 1'b0);
`else
        push(K_ERR, 16'h0003, 0, 1'b0);
`endif
        pulse_fire(16'h0003);
        repeat (4) tick();
        opp_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("multi_mask", {16'b0, fired_mask}, {16'b0, exp_mask});

        // four-cell shot exceeds every limit
        push(K_ERR, 16'h000F, 0, 1'b0);
        pulse_fire(16'h000F);
        repeat (3) tick();

        // handshake release: edge during WAIT_REL is ignored
        opp_ready = 1'b1;
        push(K_SEND, 16'h0100, 1, 1'b0);
        pulse_fire(16'h0100);
        tick();
        tick(); sel = 16'h0200; fire = 1'b1;
        repeat (3) tick();
        opp_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("no_resend", {31'b0, attack_valid}, 32'd0);
        fire = 1'b0;
        tick();
        push(K_SEND, 16'h0200, 2, 1'b0);
        pulse_fire(16'h0200);
        tick();
        tick(); opp_ready = 1'b1;
        tick(); opp_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("release_mask", {16'b0, fired_mask}, {16'b0, exp_mask});
        chk("release_count", {27'b0, shot_count}, {27'b0, exp_cnt});

        // win during SEND
        push(K_SEND, 16'h0800, 0, 1'b1);
        push(K_WON, 16'h0, 0, 1'b0);
        pulse_fire(16'h0800);
        tick();
        @(negedge clk);
        chk("win_send_valid", {31'b0, attack_valid}, 32'd1);
        opp_alive = 1'b0;
        tick();
        @(negedge clk);
        chk("won_set", {31'b0, won}, 32'd1);
        chk("won_valid_low", {31'b0, attack_valid}, 32'd0);
        chk("won_mask_kept", {16'b0, fired_mask}, {16'b0, exp_mask});
        pulse_fire(16'h1000);
        opp_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("won_sticky", {31'b0, won}, 32'd1);
        chk("won_ignores_fire", {31'b0, attack_valid}, 32'd0);
        chk("won_no_err", {31'b0, err}, 32'd0);
        opp_ready = 1'b0;

        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_mask = '0;
        exp_cnt  = '0;
        @(negedge clk);
        chk("clr_won", {31'b0, won}, 32'd0);
        chk("clr_mask", {16'b0, fired_mask}, 32'h0);
        chk("clr_count", {27'b0, shot_count}, 32'd0);

        // clr mid-handshake
        push(K_SEND, 16'h0001, 0, 1'b1);
        pulse_fire(16'h0001);
        tick();
        @(negedge clk);
        chk("clr_mid_valid_before", {31'b0, attack_valid}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_mid_valid", {31'b0, attack_valid}, 32'd0);
        chk("clr_mid_mask", {16'b0, fired_mask}, 32'h0);
        chk("clr_mid_won", {31'b0, won}, 32'd0);

        repeat (3) tick();
        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
